full_adder_seq: RTL and testbench

//   Registered full adder: sum/carry of a + b + cin, WIDTH bits wide; WIDTH=1 is the classic 1-bit full adder.

---
 rtl/full_adder_pkg.sv | 17 +
 rtl/full_adder_bit.sv | 13 +
 rtl/full_adder_seq.sv | 67 ++++++
 tb/tb_full_adder_seq.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared definitions for the full-adder slice: default width and a
// reference {cout,sum} function usable by RTL checks and benches.
package full_adder_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;
  localparam int FA_MAX_WIDTH     = 32;

  // Operands are zero-extended by the caller, so the exact result always fits.
  function automatic logic [FA_MAX_WIDTH:0] fa_ref(
    input logic [FA_MAX_WIDTH-1:0] a,
    input logic [FA_MAX_WIDTH-1:0] b,
    input logic                    cin
  );
    return {1'b0, a} + {1'b0, b} + {{FA_MAX_WIDTH{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit combinational full-adder cell, the link of the ripple chain.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder_seq.sv
// WIDTH-bit ripple-carry adder with an optional output register stage
// (REG_OUT=1: latency 1; REG_OUT=0: purely combinational).
module full_adder_seq
  import full_adder_pkg::*;
#(
  parameter int WIDTH   = FA_DEFAULT_WIDTH,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_bit u_bit (
      .a  (a[i]),
      .b  (b[i]),
      .cin(c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  if (REG_OUT != 0) begin : g_reg
    localparam int RW = FA_MAX_WIDTH + 1;

    always_ff @(posedge clk) begin
      if (!reset) begin
        sum       <= '0;
        cout      <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          sum  <= s;
          cout <= c[WIDTH];
        end
      end
    end

    logic [FA_MAX_WIDTH:0] ref_full;
    assign ref_full = fa_ref(FA_MAX_WIDTH'(a), FA_MAX_WIDTH'(b), cin);

    a_result: assert property (@(posedge clk) disable iff (!reset)
      out_valid |-> (RW'({cout, sum}) == $past(ref_full)));
  end else begin : g_comb
    // Clock and reset are intentionally ignored in the combinational build.
    logic ctrl_unused;
    assign ctrl_unused = clk ^ reset;

    assign sum       = s;
    assign cout      = c[WIDTH];
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_full_adder_seq.sv
// Directed and random checks of full_adder_seq in 1/8/16-bit, registered
// and combinational builds, against hand-computed and bench-computed results.
module tb_full_adder_seq;

  logic clk = 1'b0;
  logic reset;

  logic        v1,  a1,  b1,  ci1;
  logic        v8,  ci8;
  logic [7:0]  a8,  b8;
  logic        v16, ci16;
  logic [15:0] a16, b16;

  logic        s1,  co1,  ov1;
  logic [7:0]  s8;
  logic        co8, ov8;
  logic [15:0] s16;
  logic        co16, ov16;
  logic        cs1, cco1, cov1;
  logic [15:0] cs16;
  logic        cco16, cov16;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  full_adder_seq #(.WIDTH(1), .REG_OUT(1)) u_r1 (
    .clk(clk), .reset(reset), .in_valid(v1), .a(a1), .b(b1), .cin(ci1),
    .sum(s1), .cout(co1), .out_valid(ov1));

  full_adder_seq #(.WIDTH(8), .REG_OUT(1)) u_r8 (
    .clk(clk), .reset(reset), .in_valid(v8), .a(a8), .b(b8), .cin(ci8),
    .sum(s8), .cout(co8), .out_valid(ov8));

  full_adder_seq #(.WIDTH(16), .REG_OUT(1)) u_r16 (
    .clk(clk), .reset(reset), .in_valid(v16), .a(a16), .b(b16), .cin(ci16),
    .sum(s16), .cout(co16), .out_valid(ov16));

  full_adder_seq #(.WIDTH(1), .REG_OUT(0)) u_c1 (
    .clk(clk), .reset(reset), .in_valid(v1), .a(a1), .b(b1), .cin(ci1),
    .sum(cs1), .cout(cco1), .out_valid(cov1));

  full_adder_seq #(.WIDTH(16), .REG_OUT(0)) u_c16 (
    .clk(clk), .reset(reset), .in_valid(v16), .a(a16), .b(b16), .cin(ci16),
    .sum(cs16), .cout(cco16), .out_valid(cov16));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 1-bit truth table indexed by {a,b,cin}, value {cout,sum}
  logic [1:0] tt [8];

  initial begin
    logic [16:0] e16, held16;
    logic [1:0]  e1, held1;
    logic [2:0]  idx;

    tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    reset = 1'b0;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    v16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1;

    // Reset held for two cycles with valid operands present
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_r1", {ov1, co1, s1}, 32'h0);
      check("rst_r8", {ov8, co8, s8}, 32'h0);
      check("rst_r16", {ov16, co16, s16}, 32'h0);
    end

    // 1-bit sweep of all operand combinations
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      {a1, b1, ci1} = idx;
      v1 = 1'b1;
      #1;
      check($sformatf("comb1_%0d", i), {cov1, cco1, cs1}, {29'd0, 1'b1, tt[i]});
      tick();
      check($sformatf("reg1_%0d", i), {ov1, co1, s1}, {29'd0, 1'b1, tt[i]});
    end

    // 8-bit carry boundaries
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1;
    tick();
    check("r8_ff_00_1", {ov8, co8, s8}, {23'd0, 1'b1, 1'b1, 8'h00});
    a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0;
    tick();
    check("r8_7f_01_0", {ov8, co8, s8}, {23'd0, 1'b1, 1'b0, 8'h80});
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    tick();
    check("r8_ff_ff_1", {ov8, co8, s8}, {23'd0, 1'b1, 1'b1, 8'hFF});

    // Single valid pulse, then hold with changing operands
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1;
    tick();
    check("pulse", {ov8, co8, s8}, {23'd0, 1'b1, 1'b0, 8'h47});
    v8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    tick();
    check("hold1", {ov8, co8, s8}, {23'd0, 1'b0, 1'b0, 8'h47});
    tick();
    check("hold2", {ov8, co8, s8}, {23'd0, 1'b0, 1'b0, 8'h47});

    // Reset mid-stream with valid operands every cycle
    v8 = 1'b1; a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0;
    tick();
    check("mid_pre", {ov8, co8, s8}, {23'd0, 1'b1, 1'b0, 8'h30});
    reset = 1'b0; a8 = 8'h01; b8 = 8'h01;
    tick();
    check("mid_rst", {ov8, co8, s8}, 32'h0);
    reset = 1'b1; a8 = 8'h90; b8 = 8'h80; ci8 = 1'b1;
    tick();
    check("mid_post", {ov8, co8, s8}, {23'd0, 1'b1, 1'b1, 8'h11});

    // Random traffic with known starting state
    reset = 1'b0;
    tick();
    reset = 1'b1;
    held1 = 2'b00;
    held16 = 17'd0;
    for (int n = 0; n < 2000; n++) begin
      v1 = 1'($urandom_range(0, 3) != 0);
      a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
      v16 = 1'($urandom_range(0, 3) != 0);
      a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
      e1  = 2'(a1) + 2'(b1) + 2'(ci1);
      e16 = 17'(a16) + 17'(b16) + 17'(ci16);
      #1;
      check("rnd_c1", {cov1, cco1, cs1}, {29'd0, v1, e1});
      check("rnd_c16", {cov16, cco16, cs16}, {14'd0, v16, e16});
      tick();
      if (v1) held1 = e1;
      if (v16) held16 = e16;
      check("rnd_r1", {ov1, co1, s1}, {29'd0, v1, held1});
      check("rnd_r16", {ov16, co16, s16}, {14'd0, v16, held16});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
